// File: rtl/ar429_pkg.sv
// ARINC-429 shared definitions: line rates, rate-select codes, transmit
// FSM states and the half-bit length computation used by both TX and RX.
package ar429_pkg;

   localparam int NT_W      = 11;
   localparam int RATE_1M   = 1000000;
   localparam int RATE_100K = 100000;
   localparam int RATE_50K  = 50000;
   localparam int RATE_12K5 = 12500;

   localparam logic [1:0] NVEL_1M   = 2'd3;
   localparam logic [1:0] NVEL_100K = 2'd2;
   localparam logic [1:0] NVEL_50K  = 2'd1;
   localparam logic [1:0] NVEL_12K5 = 2'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2,
      GAP  = 2'd3
   } tx_state_t;

   // Half-bit length in clocks; evaluated at elaboration time only.
   function automatic logic [NT_W-1:0] nt_of(input int fclk, input int rate);
      return NT_W'(fclk / (2 * rate));
   endfunction

endpackage

// File: rtl/ar429_tick.sv
// Half-bit timer: free-runs while enabled, restarts on load, and flags the
// last (tick) and second-to-last (pre) clock of every half-bit.
module ar429_tick
   import ar429_pkg::*;
#(
   parameter int FCLK = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic       i_en,
   input  logic [1:0] i_nvel,
   output logic       o_tick,
   output logic       o_pre
);

   localparam logic [NT_W-1:0] NT_1M   = nt_of(FCLK, RATE_1M);
   localparam logic [NT_W-1:0] NT_100K = nt_of(FCLK, RATE_100K);
   localparam logic [NT_W-1:0] NT_50K  = nt_of(FCLK, RATE_50K);
   localparam logic [NT_W-1:0] NT_12K5 = nt_of(FCLK, RATE_12K5);

   logic [NT_W-1:0] r_cnt;
   logic [NT_W-1:0] w_nt;

   always_comb begin
      w_nt = NT_12K5;
      case (i_nvel)
         NVEL_1M:   w_nt = NT_1M;
         NVEL_100K: w_nt = NT_100K;
         NVEL_50K:  w_nt = NT_50K;
         default:   w_nt = NT_12K5;
      endcase
   end

   assign o_tick = (r_cnt == w_nt - NT_W'(1));
   assign o_pre  = (r_cnt == w_nt - NT_W'(2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load || !i_en || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + NT_W'(1);
      end
   end

endmodule

// File: rtl/ar429_txd.sv
// ARINC-429 word transmitter: serialises label (MSB first), data (LSB first)
// and odd parity as bipolar RZ on two line-driver legs, then a null gap.
module ar429_txd
   import ar429_pkg::*;
#(
   parameter int FCLK     = 50000000,
   parameter int GAP_BITS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  nvel,
   input  logic        st,
   input  logic [7:0]  adr,
   input  logic [22:0] dat,
   output logic        txd1,
   output logic        txd0,
   output logic        busy,
   output logic        done
);

   localparam int GAP_HALVES = 2 * GAP_BITS;
   localparam int GW         = $clog2(GAP_HALVES + 1);

   tx_state_t     r_state;
   logic [31:0]   r_frame;
   logic [1:0]    r_nvel;
   logic [4:0]    r_bit;
   logic [GW-1:0] r_gcnt;
   logic          r_txd1;
   logic          r_txd0;
   logic          r_busy;
   logic          r_done;

   logic [31:0]   w_frame;
   logic          w_load;
   logic          w_tick;
   logic          w_pre;
   logic          w_gap_last;

   // Transmit order is frame[31] first: label MSB..LSB, data LSB..MSB, parity.
   always_comb begin
      w_frame        = '0;
      w_frame[31:24] = adr;
      for (int i = 0; i < 23; i++) begin
         w_frame[23-i] = dat[i];
      end
      w_frame[0]     = ~^{adr, dat};
   end

   assign w_load     = (r_state == IDLE) && st;
   assign w_gap_last = (r_gcnt == GW'(GAP_HALVES - 1));

   ar429_tick #(
      .FCLK (FCLK)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_en   (r_state != IDLE),
      .i_nvel (r_nvel),
      .o_tick (w_tick),
      .o_pre  (w_pre)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_frame <= '0;
         r_nvel  <= 2'd0;
         r_bit   <= '0;
         r_gcnt  <= '0;
         r_txd1  <= 1'b0;
         r_txd0  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (st) begin
                  r_frame <= w_frame;
                  r_nvel  <= nvel;
                  r_bit   <= '0;
                  r_txd1  <= w_frame[31];
                  r_txd0  <= ~w_frame[31];
                  r_busy  <= 1'b1;
                  r_state <= HI;
               end
            end
            HI: begin
               if (w_tick) begin
                  r_txd1  <= 1'b0;
                  r_txd0  <= 1'b0;
                  r_state <= LO;
               end
            end
            LO: begin
               if (w_tick) begin
                  if (r_bit == 5'd31) begin
                     r_gcnt  <= '0;
                     r_state <= GAP;
                  end else begin
                     r_bit   <= r_bit + 5'd1;
                     r_frame <= {r_frame[30:0], 1'b0};
                     r_txd1  <= r_frame[30];
                     r_txd0  <= ~r_frame[30];
                     r_state <= HI;
                  end
               end
            end
            GAP: begin
               // done is registered one clock early so it lands on the last gap clock.
               r_done <= w_gap_last && w_pre;
               if (w_tick) begin
                  if (w_gap_last) begin
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_gcnt <= r_gcnt + GW'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign txd1 = r_txd1;
   assign txd0 = r_txd0;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_ar429_txd.sv
// Scoreboard bench for ar429_txd: words are queued when started and checked
// against a line decoder that rebuilds each word from txd1/txd0.
`timescale 1ns/1ps
module tb_ar429_txd;

   localparam int TB_FCLK = 4000000;
   localparam int TB_GAP  = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  nvel;
   logic        st;
   logic [7:0]  adr;
   logic [22:0] dat;
   logic        txd1;
   logic        txd0;
   logic        busy;
   logic        done;

   typedef struct {
      logic [7:0]  adr;
      logic [22:0] dat;
      int          nt;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   m_words = 0;

   ar429_txd #(
      .FCLK     (TB_FCLK),
      .GAP_BITS (TB_GAP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .nvel  (nvel),
      .st    (st),
      .adr   (adr),
      .dat   (dat),
      .txd1  (txd1),
      .txd0  (txd0),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int nt_model(input logic [1:0] nv);
      case (nv)
         2'd3:    return TB_FCLK / (2 * 1000000);
         2'd2:    return TB_FCLK / (2 * 100000);
         2'd1:    return TB_FCLK / (2 * 50000);
         default: return TB_FCLK / (2 * 12500);
      endcase
   endfunction

   // Line decoder / word checker
   logic [1:0]  m_lvl;
   logic [1:0]  lvl;
   logic [31:0] m_word;
   logic [22:0] m_dat;
   int m_bits, m_run, m_hi_bad, m_lo_bad, m_ovl, m_busy_cnt, m_done_cnt, cur_nt;
   logic m_prev_busy, m_prev_done;
   exp_t e;

   initial begin
      m_lvl = 2'b00; m_word = '0; m_bits = 0; m_run = 0; m_hi_bad = 0; m_lo_bad = 0;
      m_ovl = 0; m_busy_cnt = 0; m_done_cnt = 0; m_prev_busy = 1'b0; m_prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_lvl = 2'b00; m_word = '0; m_bits = 0; m_run = 0; m_hi_bad = 0; m_lo_bad = 0;
            m_ovl = 0; m_busy_cnt = 0; m_done_cnt = 0; m_prev_busy = 1'b0; m_prev_done = 1'b0;
         end else begin
            cur_nt = (q.size() > 0) ? q[0].nt : 0;
            lvl = {txd1, txd0};
            if (lvl == 2'b11) m_ovl++;
            if (lvl != m_lvl) begin
               if (m_lvl != 2'b00) begin
                  if (m_run != cur_nt) m_hi_bad++;
                  if (m_bits < 32) m_word[31-m_bits] = (m_lvl == 2'b10);
                  m_bits++;
               end else if (m_bits > 0 && m_bits < 32) begin
                  if (m_run != cur_nt) m_lo_bad++;
               end
               m_run = 1;
               m_lvl = lvl;
            end else begin
               m_run++;
            end
            if (busy) m_busy_cnt++;
            if (done) m_done_cnt++;
            if (m_prev_busy && !busy) begin
               if (q.size() == 0) begin
                  chk("unexpected_word", 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  for (int k = 0; k < 23; k++) m_dat[k] = m_word[23-k];
                  chk("bits", m_bits, 32);
                  chk("adr", {24'd0, m_word[31:24]}, {24'd0, e.adr});
                  chk("dat", {9'd0, m_dat}, {9'd0, e.dat});
                  chk("parity_bit", {31'd0, m_word[0]}, {31'd0, ~^{e.adr, e.dat}});
                  chk("ones_odd", {31'd0, ^m_word}, 32'd1);
                  chk("hi_len_errs", m_hi_bad, 0);
                  chk("lo_len_errs", m_lo_bad, 0);
                  chk("busy_len", m_busy_cnt, (64 + 2 * TB_GAP) * e.nt);
                  chk("done_cnt", m_done_cnt, 1);
                  chk("done_last_cycle", {31'd0, m_prev_done}, 32'd1);
                  chk("overlap", m_ovl, 0);
               end
               m_words++;
               m_bits = 0; m_word = '0; m_hi_bad = 0; m_lo_bad = 0; m_ovl = 0;
               m_busy_cnt = 0; m_done_cnt = 0;
            end
            m_prev_busy = busy;
            m_prev_done = done;
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [22:0] d, input logic [1:0] nv);
      exp_t x;
      int n;
      n = 0;
      while (busy && n < 20000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      adr = a; dat = d; nvel = nv; st = 1'b1;
      x.adr = a; x.dat = d; x.nt = nt_model(nv);
      q.push_back(x);
      @(negedge clk);
      st = 1'b0;
      adr = 8'($urandom); dat = 23'($urandom); nvel = 2'($urandom);
   endtask

   task automatic wait_words(input int n);
      int c;
      c = 0;
      while (m_words < n && c < 15000) begin
         @(negedge clk);
         c++;
      end
      chk("word_seen", {31'd0, (m_words >= n)}, 32'd1);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int c;
      logic [1:0] nv;
      rst_n = 1'b0; st = 1'b0; adr = '0; dat = '0; nvel = 2'd3;
      repeat (3) @(negedge clk);
      chk("rst_txd1", {31'd0, txd1}, 32'd0);
      chk("rst_txd0", {31'd0, txd0}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      send(8'hA5, 23'h000001, 2'd3);
      wait_words(1);
      send(8'h00, 23'h000000, 2'd3);
      wait_words(2);

      // start strobe while busy is dropped
      send(8'h3C, 23'h012345, 2'd3);
      repeat (99) @(negedge clk);
      adr = 8'hFF; dat = 23'h7FFFFF; st = 1'b1;
      @(negedge clk);
      st = 1'b0;
      wait_words(3);

      // start strobe coinciding with done is dropped
      send(8'h81, 23'h7FFFFF, 2'd3);
      c = 0;
      while (!done && c < 2000) begin
         @(negedge clk);
         c++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      st = 1'b1;
      @(negedge clk);
      st = 1'b0;
      wait_words(4);
      repeat (3) @(negedge clk);
      chk("st_on_done_busy", {31'd0, busy}, 32'd0);

      // slowest rate, rate select toggled mid-word
      send(8'h5A, 23'h2AAAAA, 2'd0);
      repeat (500) @(negedge clk);
      nvel = 2'd3;
      wait_words(5);
      send(8'hC3, 23'h0F0F0F, 2'd1);
      wait_words(6);

      // asynchronous reset during bit 10
      send(8'hE7, 23'h001234, 2'd3);
      repeat (40) @(negedge clk);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      chk("pre_rst_line", {31'd0, (txd1 | txd0)}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_txd1", {31'd0, txd1}, 32'd0);
      chk("arst_txd0", {31'd0, txd0}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      send(8'hE7, 23'h001234, 2'd3);
      wait_words(7);

      for (int i = 0; i < 200; i++) begin
         nv = ($urandom_range(0, 15) == 0) ? 2'd2 : 2'd3;
         send(8'($urandom), 23'($urandom), nv);
         wait_words(8 + i);
      end

      repeat (5) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
